param_regfile: RTL and testbench
================================

// Module: param_regfile
// PURPOSE
//  Parametrised 2-read/1-write register file for the datapath; successor to the fixed 32x32 file.
//  Storage is a reset-less array so synthesis can infer RAM; a built-in init sequencer clears it after reset or on request.
//  Reads are registered: 1-cycle latency.
//  Register 0 is optionally hard-wired to zero.
// PARAMETERS
//  DATA_W    32  data word width (bits)
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  Clk    in   1       clock, all state on rising edge
//  Rst_n  in   1       asynchronous active-low reset
//  Clear  in   1       synchronous request to re-zero the whole array
//  Ready  out  1       1 = init sweep done, file accepts writes
//  Ard1   in   ADDR_W  read address, port 1
//  Ard2   in   ADDR_W  read address, port 2
//  Dout1  out  DATA_W  registered read data, port 1
//  Dout2  out  DATA_W  registered read data, port 2
//  Awr    in   ADDR_W  write address
//  Din    in   DATA_W  write data
//  WrEn   in   1       write enable (qualified by Ready)
// BEHAVIOUR
//  - Reset (Rst_n=0, async): FSM=INIT, sweep counter=0, Ready=0, Dout1=Dout2=0. Array contents are not reset.
//  - FSM states:
//    - INIT: write 0 to mem[cnt]; cnt++ each cycle.
//      Exit to READY on the cycle after cnt==DEPTH-1 is written, so the sweep takes exactly DEPTH cycles.
//    - READY: Ready=1.
//      Clear=1 -> cnt=0, next state INIT; Ready falls on the next edge.
//    - Clear while in INIT restarts the sweep at cnt=0.
//  - Write: if state==READY && WrEn && !(ZERO_REG && Awr==0), then mem[Awr] <= Din at the edge.
//    - WrEn is ignored while Ready=0 (no queueing, no error flag).
//    - A write in the same cycle as Clear is performed; the sweep later overwrites it with 0.
//  - Read: each edge, DoutN <= mem[ArdN], or 0 if ZERO_REG && ArdN==0.
//    - Reads are legal in any state; during INIT they return the partly swept contents.
//    - Ready=0 tells the consumer to ignore them.
//  - Same-cycle read/write to the same address: see CONFIGURATION.
//    Both read ports follow the same rule, independently.
//  - The sweep counter is ADDR_W+1 bits wide; there is no wrap-around inside INIT.
//  - Reset asserted mid-sweep or mid-write: the async clear wins immediately; the sweep restarts after Rst_n rises.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Same-cycle read and write to the same address (write accepted, not to zero reg): DoutN <= Din (write-first).
//  REGFILE_BYPASS_EN undefined:
//    - DoutN <= old mem value (read-first); new data visible from the following read.
// STRUCTURE
//  - Shared package regfile_pkg:
//    - typedef rf_state_t {RF_INIT, RF_READY}
//    - default DATA_W/ADDR_W localparams
//  - Sub-module regfile_init_seq: FSM + sweep counter.
//    - Outputs: Ready, init_we, init_addr.
//  - Top-level param_regfile:
//    - write-port mux: init vs. user
//    - array
//    - two read ports with optional bypass
// TESTING
//  1. Reset release, DEPTH=32 -> Ready=0 for exactly 32 cycles, then 1; all 32 reads return 0.
//  2. Write Awr=5, Din=32'hDEADBEEF; next cycle Ard1=5 -> Dout1=32'hDEADBEEF one cycle later.
//     Ard2=5 in the same cycle gives the same value.
//  3. ZERO_REG=1: write Awr=0, Din=32'h1234 -> Dout1 for Ard1=0 stays 0.
//     ZERO_REG=0 build returns 32'h1234.
//  4. Same-cycle write/read to addr 7 (old 32'hA, Din=32'hB) -> Dout1=32'hB with REGFILE_BYPASS_EN.
//     Without the macro: 32'hA, then 32'hB on the next read.
//  5. In READY, write regs 1..4; pulse Clear -> Ready=0 for 32 cycles; writes issued meanwhile are dropped.
//     Afterwards all regs read 0.
//  6. Assert Rst_n=0 at sweep count 10 -> Dout1=Dout2=0 and Ready=0 at once.
//     After release, Ready rises exactly 32 cycles later.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: after reset or Clear, sweeps every entry with zero
// (one entry per cycle), then reports Ready and hands the write port
// over to the user.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam int          DEPTH = 1 << ADDR_W;
  // One extra counter bit so DEPTH-1 compares without wrap concerns.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  rf_state_t       state;
  logic [ADDR_W:0] cnt;

  assign init_addr = cnt[ADDR_W-1:0];

  // FSM: zero one entry per cycle in INIT, leave after the last one,
  // and restart the sweep whenever Clear is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_INIT;
      cnt     <= '0;
      ready   <= 1'b0;
      init_we <= 1'b1;
    end else begin
      case (state)
        RF_INIT: begin
          if (clear) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state   <= RF_READY;
            ready   <= 1'b1;
            init_we <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RF_READY: begin
          if (clear) begin
            state   <= RF_INIT;
            ready   <= 1'b0;
            init_we <= 1'b1;
            cnt     <= '0;
          end
        end
        default: begin
          state   <= RF_INIT;
          ready   <= 1'b0;
          init_we <= 1'b1;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised 2-read/1-write register file with registered reads.
// Storage has no reset so it can map to RAM; regfile_init_seq zeroes it.
// Build option: REGFILE_BYPASS_EN makes a read of the address being
// written in the same cycle return the new data (write-first); without
// it reads return the old contents (read-first).
module param_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clear,
  output logic              Ready,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit ZERO_EN  = (ZERO_REG != 0);

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_q;

  regfile_init_seq #(.ADDR_W(ADDR_W)) u_init (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .clear     (Clear),
    .ready     (Ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // User writes only land once the sweep is done; entry 0 is read-only
  // when hard-wired to zero.
  assign user_we  = Ready && WrEn && !(ZERO_EN && (Awr == '0));

  // Write-port mux: the sweep owns the port while it runs.
  assign mem_we   = init_we || user_we;
  assign mem_addr = init_we ? init_addr : Awr;
  assign mem_data = init_we ? '0 : Din;

  assign rd_addr  = {Ard2, Ard1};
  assign Dout1    = rd_q[0];
  assign Dout2    = rd_q[1];

  // Storage array, no reset so it stays RAM-inferable.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  // Registered read ports, each applying the zero-reg and bypass rules
  // independently.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ZERO_EN && (rd_addr[p] == '0))
          rd_q[p] <= '0;
`ifdef REGFILE_BYPASS_EN
        else if (user_we && (Awr == rd_addr[p]))
          rd_q[p] <= Din;
`endif
        else
          rd_q[p] <= mem[rd_addr[p]];
      end
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile: two instances (zero-reg on/off)
// share all inputs; expected values are hand-computed constants.
module tb_param_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [AW-1:0] ard1, ard2, awr;
  logic [DW-1:0] din;
  logic          wren;

  logic          rdy_z, rdy_n;
  logic [DW-1:0] d1_z, d2_z, d1_n, d2_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_z (
    .Clk(clk), .Rst_n(rst_n), .Clear(clear), .Ready(rdy_z),
    .Ard1(ard1), .Ard2(ard2), .Dout1(d1_z), .Dout2(d2_z),
    .Awr(awr), .Din(din), .WrEn(wren)
  );

  param_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_n (
    .Clk(clk), .Rst_n(rst_n), .Clear(clear), .Ready(rdy_n),
    .Ard1(ard1), .Ard2(ard2), .Dout1(d1_n), .Dout2(d2_n),
    .Awr(awr), .Din(din), .WrEn(wren)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until Ready rises; gives up after a bounded number.
  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy_z && n < 100) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; clear = 1'b0; wren = 1'b0;
    ard1 = '0; ard2 = '0; awr = '0; din = '0;
    #2;
    // 1. reset state
    chk("rst_ready", {31'd0, rdy_z}, 32'd0);
    chk("rst_dout1", d1_z, 32'd0);
    chk("rst_dout2", d2_z, 32'd0);
    step(); step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("init_cycles", n, 32'd32);
    chk("init_ready_nz", {31'd0, rdy_n}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      ard1 = AW'(i); ard2 = AW'(31 - i);
      step();
      chk($sformatf("init_rd1_%0d", i), d1_z, 32'd0);
      chk($sformatf("init_rd2_%0d", i), d2_n, 32'd0);
    end

    // 2. write then read on both ports
    wren = 1'b1; awr = 5'd5; din = 32'hDEADBEEF;
    step();
    wren = 1'b0; ard1 = 5'd5; ard2 = 5'd5;
    step();
    chk("wr5_dout1", d1_z, 32'hDEADBEEF);
    chk("wr5_dout2", d2_z, 32'hDEADBEEF);

    // 3. zero register
    wren = 1'b1; awr = 5'd0; din = 32'h1234;
    step();
    wren = 1'b0; ard1 = 5'd0; ard2 = 5'd0;
    step();
    chk("zero_reg_on", d1_z, 32'd0);
    chk("zero_reg_on_p2", d2_z, 32'd0);
    chk("zero_reg_off", d1_n, 32'h1234);

    // 4. same-cycle read/write to addr 7
    wren = 1'b1; awr = 5'd7; din = 32'hA;
    step();
    din = 32'hB; ard1 = 5'd7; ard2 = 5'd7;
    step();
    wren = 1'b0;
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_p1", d1_z, 32'hB);
    chk("rw_same_p2", d2_z, 32'hB);
`else
    chk("rw_same_p1", d1_z, 32'hA);
    chk("rw_same_p2", d2_z, 32'hA);
`endif
    step();
    chk("rw_next", d1_z, 32'hB);

    // 5. Clear: writes during the sweep dropped, everything reads 0
    for (int i = 1; i <= 4; i++) begin
      wren = 1'b1; awr = AW'(i); din = 32'h10 + i;
      step();
    end
    wren = 1'b0; ard1 = 5'd4;
    step();
    chk("pre_clear_r4", d1_z, 32'h14);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_ready_fall", {31'd0, rdy_z}, 32'd0);
    wren = 1'b1; awr = 5'd3; din = 32'hFFFF;
    n = 0;
    while (!rdy_z && n < 100) begin
      step();
      n++;
    end
    wren = 1'b0;
    chk("clear_cycles", n, 32'd32);
    for (int i = 0; i <= 7; i++) begin
      ard1 = AW'(i); ard2 = AW'(i);
      step();
      chk($sformatf("post_clear_r%0d", i), d1_n, 32'd0);
    end

    // 6. reset in the middle of a sweep
    wren = 1'b1; awr = 5'd20; din = 32'h77;
    step();
    wren = 1'b0; ard1 = 5'd20; ard2 = 5'd20; clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("midsweep_rd", d1_z, 32'h77);
    chk("midsweep_ready", {31'd0, rdy_z}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_dout1", d1_z, 32'd0);
    chk("async_dout2", d2_z, 32'd0);
    chk("async_ready", {31'd0, rdy_z}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("rerst_cycles", n, 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
